// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with freeze (hold), flush (bubble) and a saturating bubble counter.
// Optional macro FORWARD_EN adds the src1/src2 register numbers used by the forwarding unit.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [3:0]  alu_command_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        wb_enb_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  status_in,
`ifdef FORWARD_EN
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
`endif
  output logic [31:0] pc_out,
  output logic [3:0]  alu_command_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        wb_enb_out,
  output logic        b_out,
  output logic        s_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic        imm_out,
  output logic [11:0] shift_operand_out,
  output logic [23:0] signed_imm24_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  status_out,
  output logic        valid_out,
  output logic [7:0]  bubble_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_command;
    logic        mem_read;
    logic        mem_write;
    logic        wb_enb;
    logic        b;
    logic        s;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [3:0]  dest;
    logic [3:0]  status;
`ifdef FORWARD_EN
    logic [3:0]  src1;
    logic [3:0]  src2;
`endif
  } stage_t;

  stage_t     stage_d, stage_q, stage_in;
  logic       valid_d, valid_q;
  logic [7:0] cnt_d, cnt_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    stage_in               = '0;
    stage_in.pc            = pc_in;
    stage_in.alu_command   = alu_command_in;
    stage_in.mem_read      = mem_read_in;
    stage_in.mem_write     = mem_write_in;
    stage_in.wb_enb        = wb_enb_in;
    stage_in.b             = b_in;
    stage_in.s             = s_in;
    stage_in.val_rn        = val_rn_in;
    stage_in.val_rm        = val_rm_in;
    stage_in.imm           = imm_in;
    stage_in.shift_operand = shift_operand_in;
    stage_in.signed_imm24  = signed_imm24_in;
    stage_in.dest          = dest_in;
    stage_in.status        = status_in;
`ifdef FORWARD_EN
    stage_in.src1          = src1_in;
    stage_in.src2          = src2_in;
`endif
  end

  // Freeze outranks flush; a bubble zeroes every field so its control bits cause no side effect.
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      if (flush) begin
        stage_d = '0;
        valid_d = 1'b0;
        cnt_d   = sat_inc(cnt_q);
      end else begin
        stage_d = stage_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out            = stage_q.pc;
  assign alu_command_out   = stage_q.alu_command;
  assign mem_read_out      = stage_q.mem_read;
  assign mem_write_out     = stage_q.mem_write;
  assign wb_enb_out        = stage_q.wb_enb;
  assign b_out             = stage_q.b;
  assign s_out             = stage_q.s;
  assign val_rn_out        = stage_q.val_rn;
  assign val_rm_out        = stage_q.val_rm;
  assign imm_out           = stage_q.imm;
  assign shift_operand_out = stage_q.shift_operand;
  assign signed_imm24_out  = stage_q.signed_imm24;
  assign dest_out          = stage_q.dest;
  assign status_out        = stage_q.status;
`ifdef FORWARD_EN
  assign src1_out          = stage_q.src1;
  assign src2_out          = stage_q.src2;
`endif
  assign valid_out         = valid_q;
  assign bubble_cnt        = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a behavioural model of the load/freeze/flush/reset rules.
module tb_id_ex_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, freeze, flush;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [3:0]  alu_command_in, dest_in, status_in;
  logic        mem_read_in, mem_write_in, wb_enb_in, b_in, s_in, imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  alu_command_out, dest_out, status_out;
  logic        mem_read_out, mem_write_out, wb_enb_out, b_out, s_out, imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic        valid_out;
  logic [7:0]  bubble_cnt;
  logic [3:0]  src1_in, src2_in, src1_out, src2_out;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .alu_command_in(alu_command_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_enb_in(wb_enb_in),
    .b_in(b_in), .s_in(s_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .status_in(status_in),
`ifdef FORWARD_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1_out(src1_out), .src2_out(src2_out),
`endif
    .pc_out(pc_out), .alu_command_out(alu_command_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .wb_enb_out(wb_enb_out),
    .b_out(b_out), .s_out(s_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm24_out(signed_imm24_out), .dest_out(dest_out), .status_out(status_out),
    .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

`ifndef FORWARD_EN
  assign src1_out = 4'd0;
  assign src2_out = 4'd0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the instruction the stage should hold, its valid bit and the bubble tally.
  logic [159:0] m_data;
  logic         m_valid;
  int           m_cnt;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] in_vec();
    logic [159:0] v;
    v = 160'({pc_in, alu_command_in, mem_read_in, mem_write_in, wb_enb_in, b_in, s_in,
              val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm24_in,
              dest_in, status_in, src1_in, src2_in});
`ifndef FORWARD_EN
    v[7:0] = 8'd0;
`endif
    return v;
  endfunction

  function automatic logic [159:0] out_vec();
    return 160'({pc_out, alu_command_out, mem_read_out, mem_write_out, wb_enb_out, b_out, s_out,
                 val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out,
                 dest_out, status_out, src1_out, src2_out});
  endfunction

  task automatic rand_in();
    pc_in            = $urandom;
    alu_command_in   = 4'($urandom);
    mem_read_in      = 1'($urandom);
    mem_write_in     = 1'($urandom);
    wb_enb_in        = 1'($urandom);
    b_in             = 1'($urandom);
    s_in             = 1'($urandom);
    val_rn_in        = $urandom;
    val_rm_in        = $urandom;
    imm_in           = 1'($urandom);
    shift_operand_in = 12'($urandom);
    signed_imm24_in  = 24'($urandom);
    dest_in          = 4'($urandom);
    status_in        = 4'($urandom);
    src1_in          = 4'($urandom);
    src2_in          = 4'($urandom);
  endtask

  task automatic zero_in();
    {pc_in, alu_command_in, mem_read_in, mem_write_in, wb_enb_in, b_in, s_in,
     val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm24_in,
     dest_in, status_in, src1_in, src2_in} = '0;
  endtask

  // One clock: advance the model by the stated rules, then compare everything just after the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_data = '0; m_valid = 1'b0; m_cnt = 0;
    end else if (freeze) begin
      // hold
    end else if (flush) begin
      m_data = '0; m_valid = 1'b0;
      if (m_cnt < 255) m_cnt++;
    end else begin
      m_data = in_vec(); m_valid = 1'b1;
    end
    #1;
    check("data", out_vec(), m_data);
    check("valid", 160'(valid_out), 160'(m_valid));
    check("bubble_cnt", 160'(bubble_cnt), 160'(m_cnt));
  endtask

  initial begin
    m_data = '0; m_valid = 1'b0; m_cnt = 0;
    rst_n = 1'b0; freeze = 1'($urandom); flush = 1'($urandom);
    rand_in();
    step();
    rand_in();
    step();
    check("rst_valid", 160'(valid_out), 160'(0));
    check("rst_pc", 160'(pc_out), 160'(0));

    // Basic load, one-cycle latency
    rst_n = 1'b1; freeze = 1'b0; flush = 1'b0;
    zero_in();
    pc_in = 32'h10; alu_command_in = 4'b0010; wb_enb_in = 1'b1; dest_in = 4'd3;
    step();
    check("load_pc", 160'(pc_out), 160'(32'h10));
    check("load_alu", 160'(alu_command_out), 160'(4'b0010));
    check("load_wb", 160'(wb_enb_out), 160'(1));
    check("load_dest", 160'(dest_out), 160'(3));
    check("load_valid", 160'(valid_out), 160'(1));

    // Freeze holds across changing inputs
    rand_in(); val_rn_in = 32'hDEADBEEF;
    step();
    freeze = 1'b1;
    repeat (5) begin
      rand_in();
      step();
      check("freeze_rn", 160'(val_rn_out), 160'(32'hDEADBEEF));
    end
    freeze = 1'b0; rand_in();
    step();
    check("release_rn", 160'(val_rn_out), 160'(val_rn_in));

    // Flush kills a store
    rand_in(); mem_write_in = 1'b1;
    step();
    check("pre_flush_mw", 160'(mem_write_out), 160'(1));
    flush = 1'b1; rand_in();
    step();
    check("flush_mw", 160'(mem_write_out), 160'(0));
    check("flush_valid", 160'(valid_out), 160'(0));
    check("flush_cnt", 160'(bubble_cnt), 160'(1));

    // Freeze beats flush
    flush = 1'b0; rand_in();
    step();
    freeze = 1'b1; flush = 1'b1;
    repeat (3) begin rand_in(); step(); end
    check("prio_cnt", 160'(bubble_cnt), 160'(1));
    check("prio_valid", 160'(valid_out), 160'(1));

    // Conflicting read/write passes through untouched
    freeze = 1'b0; flush = 1'b0; rand_in();
    mem_read_in = 1'b1; mem_write_in = 1'b1;
    step();
    check("rw_pass", 160'({mem_read_out, mem_write_out}), 160'(2'b11));

    // Reset during freeze discards the held instruction
    freeze = 1'b1; rand_in();
    step();
    rst_n = 1'b0;
    step();
    check("rst_frz_valid", 160'(valid_out), 160'(0));
    rst_n = 1'b1; freeze = 1'b0; rand_in();
    step();
    check("post_rst_valid", 160'(valid_out), 160'(1));

    // Random mix of loads, freezes, flushes and occasional resets
    for (int i = 0; i < 2000; i++) begin
      rand_in();
      freeze = ($urandom_range(0, 9) < 3);
      flush  = ($urandom_range(0, 9) < 3);
      rst_n  = ($urandom_range(0, 99) != 0);
      step();
    end

    // Saturation
    rst_n = 1'b1; freeze = 1'b0; flush = 1'b1;
    repeat (300) begin rand_in(); step(); end
    check("sat_cnt", 160'(bubble_cnt), 160'(255));

`ifdef FORWARD_EN
    flush = 1'b0; rand_in(); src1_in = 4'd7;
    step();
    check("fwd_src1_load", 160'(src1_out), 160'(7));
    flush = 1'b1; rand_in();
    step();
    check("fwd_src1_flush", 160'(src1_out), 160'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 freeze  input  1  memory-stall hold; stage keeps its contents.
REQ-004 flush  input  1  branch-taken kill; stage loads a bubble.
REQ-005 pc_in/pc_out  input/output  32  PC+4 of the instruction.
REQ-006 alu_command_in/alu_command_out  input/output  4  decoded ALU command.
REQ-007 mem_read_in, mem_write_in, wb_enb_in, b_in, s_in (and matching *_out)  input/output  1 each  decoded control bits.
REQ-008 val_rn_in/val_rn_out, val_rm_in/val_rm_out  input/output  32 each  register-file operands.
REQ-009 imm_in/imm_out  input/output  1  immediate-operand flag.
REQ-010 shift_operand_in/shift_operand_out  input/output  12  shifter operand field.
REQ-011 signed_imm24_in/signed_imm24_out  input/output  24  branch offset.
REQ-012 dest_in/dest_out  input/output  4  destination register number.
REQ-013 status_in/status_out  input/output  4  NZCV flags captured at decode.
REQ-014 valid_out  output  1  stage holds a real instruction.
REQ-015 bubble_cnt  output  8  count of bubbles inserted by flush since reset, saturating.

Function
REQ-016 The block SHALL be a single-entry pipeline register between decode and execute, with latency exactly one cycle from *_in to *_out.
REQ-017 Per rising edge the block SHALL apply priority: rst_n low > freeze > flush > load.
REQ-018 Load (freeze=0, flush=0): every *_out register SHALL capture its *_in value, and valid_out SHALL become 1.
REQ-019 Freeze (freeze=1): all outputs SHALL hold, including valid_out and bubble_cnt, for any number of consecutive cycles.
REQ-020 Flush (freeze=0, flush=1): every *_out register SHALL clear to 0 and valid_out SHALL become 0.
REQ-021 A flush SHALL clear mem_read_out, mem_write_out, wb_enb_out, b_out and s_out, so a bubble has no architectural side effect.
REQ-022 Each flush cycle SHALL increment bubble_cnt by 1, and bubble_cnt SHALL saturate at 255 with no wrap-around.
REQ-023 When freeze and flush are asserted together, freeze SHALL win: nothing is cleared and bubble_cnt does not increment.
REQ-024 Inputs with mem_write_in=1 and mem_read_in=1 together SHALL be passed through unmodified, because the block performs no decode checking.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from input to output.

Reset
REQ-026 While rst_n is low at a rising edge, all *_out, valid_out and bubble_cnt SHALL clear to 0, regardless of freeze and flush.
REQ-027 A reset asserted mid-freeze SHALL discard the held instruction. The first edge with rst_n high SHALL then follow REQ-017.

Configuration
REQ-028 Macro FORWARD_EN: when defined, the block SHALL add src1_in/src1_out and src2_in/src2_out (4 bits each; source register numbers for the forwarding unit). These SHALL follow the same load, freeze, flush and reset rules.
REQ-029 When FORWARD_EN is undefined, those ports SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset: rst_n=0 for 2 cycles with arbitrary inputs -> all outputs 0, valid_out=0, bubble_cnt=0.
REQ-031 Load: pc_in=0x00000010, alu_command_in=4'b0010, wb_enb_in=1, dest_in=4'd3 -> exactly one edge later pc_out=0x10, alu_command_out=4'b0010, wb_enb_out=1, dest_out=3, valid_out=1.
REQ-032 Freeze: load val_rn_in=0xDEADBEEF, then freeze=1 for 5 cycles while inputs change -> val_rn_out stays 0xDEADBEEF; on release, the next edge captures the current inputs.
REQ-033 Flush: stage holds mem_write_out=1, then flush=1 for one cycle -> mem_write_out=0, valid_out=0, bubble_cnt=1.
REQ-034 Priority: freeze=1 and flush=1 together for 3 cycles -> outputs unchanged and bubble_cnt unchanged.
REQ-035 Saturation: 300 consecutive flush cycles -> bubble_cnt=255. With FORWARD_EN defined, src1_in=4'd7 loads src1_out=7 and a flush clears it to 0.
